// File: rtl/rsa_keygen_ctrl.sv
// RSA key generation sequencer: forms n=p*q and lambda=(p-1)(q-1), obtains e from an external selector, searches d.
// Latency: 4 + selector wait + d cycles from accepted start to the done pulse.
// Backpressure: start is honoured only when idle (no queueing); the selector is held off by waiting on sel_done.
// Optional macro KEYGEN_TIMEOUT_EN: bounds the selector wait to TIMEOUT cycles, then reports err.
module rsa_keygen_ctrl #(
    parameter int PW      = 4,
    parameter int KW      = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [PW-1:0] p,
    input  logic [PW-1:0] q,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [KW-1:0] n,
    output logic [KW-1:0] lambda,
    output logic [KW-1:0] e,
    output logic [KW-1:0] d,
    output logic          sel_start,
    input  logic          sel_done,
    input  logic [KW-1:0] sel_key
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_CHECK    = 3'd1;
    localparam logic [2:0] ST_CALC     = 3'd2;
    localparam logic [2:0] ST_SEL_REQ  = 3'd3;
    localparam logic [2:0] ST_SEL_WAIT = 3'd4;
    localparam logic [2:0] ST_INV      = 3'd5;
    localparam logic [2:0] ST_DONE     = 3'd6;
    localparam logic [2:0] ST_ERR      = 3'd7;

    logic [2:0]      state_q, state_d;
    logic [PW-1:0]   p_q, p_d;
    logic [PW-1:0]   q_q, q_d;
    logic [KW-1:0]   n_q, n_d;
    logic [KW-1:0]   lambda_q, lambda_d;
    logic [KW-1:0]   e_q, e_d;
    logic [KW-1:0]   d_q, d_d;
    logic [KW-1:0]   cand_q, cand_d;

    logic [2*KW-1:0] prod;
    logic [2*KW-1:0] divisor;
    logic [2*KW-1:0] residue;
    logic            inv_match;
    logic            tmo_hit;

`ifdef KEYGEN_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmo_q, tmo_d;

    // Selector-wait cycle counter: zeroed on the way into SEL_WAIT, counts every waiting cycle.
    always_comb begin
        tmo_d = tmo_q;
        if (state_q == ST_SEL_REQ) begin
            tmo_d = '0;
        end else if (state_q == ST_SEL_WAIT && !sel_done) begin
            tmo_d = tmo_q + TW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end

    // The TIMEOUT-th waiting cycle without sel_done is the last one.
    assign tmo_hit = (tmo_q == TW'(TIMEOUT - 1));
`else
    logic unused_timeout;

    // Without the timeout option the selector may take as long as it likes.
    assign tmo_hit        = 1'b0;
    assign unused_timeout = (TIMEOUT > 0);
`endif

    // Inverse test for the current candidate: (cand * e) mod lambda == 1, full double-width product.
    always_comb begin
        prod      = {{KW{1'b0}}, cand_q} * {{KW{1'b0}}, e_q};
        divisor   = {{KW{1'b0}}, (lambda_q == '0) ? KW'(1) : lambda_q};
        residue   = prod % divisor;
        inv_match = (residue == {{(2*KW-1){1'b0}}, 1'b1});
    end

    // Next-state and datapath update for the key-generation sequence.
    always_comb begin
        state_d  = state_q;
        p_d      = p_q;
        q_d      = q_q;
        n_d      = n_q;
        lambda_d = lambda_q;
        e_d      = e_q;
        d_d      = d_q;
        cand_d   = cand_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    p_d     = p;
                    q_d     = q;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (p_q < PW'(2) || q_q < PW'(2) || p_q == q_q) begin
                    d_d     = '0;
                    state_d = ST_ERR;
                end else begin
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                n_d      = KW'(p_q) * KW'(q_q);
                lambda_d = (KW'(p_q) - KW'(1)) * (KW'(q_q) - KW'(1));
                state_d  = ST_SEL_REQ;
            end
            ST_SEL_REQ: begin
                // A sel_done seen here belongs to no request of ours and is dropped.
                state_d = ST_SEL_WAIT;
            end
            ST_SEL_WAIT: begin
                if (sel_done) begin
                    e_d = sel_key;
                    if (sel_key == '0 || sel_key >= lambda_q) begin
                        d_d     = '0;
                        state_d = ST_ERR;
                    end else begin
                        cand_d  = KW'(1);
                        state_d = ST_INV;
                    end
                end else if (tmo_hit) begin
                    d_d     = '0;
                    state_d = ST_ERR;
                end
            end
            ST_INV: begin
                if (inv_match) begin
                    d_d     = cand_q;
                    state_d = ST_DONE;
                end else if (cand_q + KW'(1) >= lambda_q) begin
                    // Candidates 1..lambda-1 exhausted: e shares a factor with lambda.
                    d_d     = '0;
                    state_d = ST_ERR;
                end else begin
                    cand_d = cand_q + KW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset returns to idle with everything cleared.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            p_q      <= '0;
            q_q      <= '0;
            n_q      <= '0;
            lambda_q <= '0;
            e_q      <= '0;
            d_q      <= '0;
            cand_q   <= '0;
        end else begin
            state_q  <= state_d;
            p_q      <= p_d;
            q_q      <= q_d;
            n_q      <= n_d;
            lambda_q <= lambda_d;
            e_q      <= e_d;
            d_q      <= d_d;
            cand_q   <= cand_d;
        end
    end

    // Status strobes decode directly from the registered state, so they are glitch-free single-state pulses.
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign err       = (state_q == ST_ERR);
    assign sel_start = (state_q == ST_SEL_REQ);
    assign n         = n_q;
    assign lambda    = lambda_q;
    assign e         = e_q;
    assign d         = d_q;

endmodule

// File: tb/tb_rsa_keygen_ctrl.sv
// Directed bench for rsa_keygen_ctrl with hand-computed keys.
// Timing reference t: number of clock edges after the edge that accepted start.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_rsa_keygen_ctrl;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] p;
    logic [3:0] q;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] n;
    logic [7:0] lambda;
    logic [7:0] e;
    logic [7:0] d;
    logic       sel_start;
    logic       sel_done;
    logic [7:0] sel_key;

    int checks;
    int errors;
    int t;

    rsa_keygen_ctrl #(.PW(4), .KW(8), .TIMEOUT(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .p         (p),
        .q         (q),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .n         (n),
        .lambda    (lambda),
        .e         (e),
        .d         (d),
        .sel_start (sel_start),
        .sel_done  (sel_done),
        .sel_key   (sel_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0d)", tag, act, exp, t);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        t++;
    endtask

    // Present a request for one edge; afterwards t=0 and the DUT is in CHECK.
    task automatic begin_req(input logic [3:0] pp, input logic [3:0] qq);
        p     = pp;
        q     = qq;
        start = 1'b1;
        tick();
        start = 1'b0;
        t     = 0;
    endtask

    // From t=0: walk to SEL_WAIT (t=3), wait w cycles, pulse sel_done with key.
    task automatic provide_key(input logic [7:0] key, input int w);
        tick();
        tick();
        tick();
        repeat (w) tick();
        sel_done = 1'b1;
        sel_key  = key;
        tick();
        sel_done = 1'b0;
        sel_key  = 8'd0;
    endtask

    // Step until done or err is high, bounded by a cycle budget.
    task automatic wait_end(input string tag, input int bound);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (done || err) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk_eq(tag, {63'd0, seen}, 64'd1);
    endtask

    initial begin
        int done_cnt;
        int err_seen;
        checks   = 0;
        errors   = 0;
        t        = 0;
        reset    = 1'b0;
        start    = 1'b0;
        p        = 4'd0;
        q        = 4'd0;
        sel_done = 1'b0;
        sel_key  = 8'd0;

        // Reset state
        repeat (3) tick();
        chk_eq("reset_outs", {busy, done, err, sel_start, n, lambda, e, d}, 64'd0);
        reset = 1'b1;
        tick();
        chk_eq("idle_busy", {63'd0, busy}, 64'd0);

        // Case 1: p=5 q=11, stray sel_done in SEL_REQ ignored, real key 3 after 10 cycles
        begin_req(4'd5, 4'd11);
        chk_eq("c1_busy_t0", {63'd0, busy}, 64'd1);
        tick();
        tick();
        chk_eq("c1_sel_start", {63'd0, sel_start}, 64'd1);
        chk_eq("c1_n", {56'd0, n}, 64'd55);
        chk_eq("c1_lambda", {56'd0, lambda}, 64'd40);
        sel_done = 1'b1;
        sel_key  = 8'd7;
        tick();
        sel_done = 1'b0;
        sel_key  = 8'd0;
        chk_eq("c1_sel_start_off", {63'd0, sel_start}, 64'd0);
        chk_eq("c1_ignored_e", {56'd0, e}, 64'd0);
        repeat (10) tick();
        sel_done = 1'b1;
        sel_key  = 8'd3;
        tick();
        sel_done = 1'b0;
        sel_key  = 8'd0;
        wait_end("c1_end", 100);
        chk_eq("c1_done", {62'd0, done, err}, 64'd2);
        chk_eq("c1_latency", t, 64'd41);
        chk_eq("c1_e", {56'd0, e}, 64'd3);
        chk_eq("c1_d", {56'd0, d}, 64'd27);
        chk_eq("c1_busy_done", {63'd0, busy}, 64'd1);
        tick();
        chk_eq("c1_after", {61'd0, busy, done, err}, 64'd0);
        chk_eq("c1_hold_n", {56'd0, n}, 64'd55);

        // Case 2: p==q -> err two cycles after start, selector never requested
        begin_req(4'd3, 4'd3);
        chk_eq("c2_t0", {61'd0, busy, err, sel_start}, 64'd4);
        tick();
        chk_eq("c2_err", {61'd0, err, done, sel_start}, 64'd4);
        chk_eq("c2_d", {56'd0, d}, 64'd0);
        tick();
        chk_eq("c2_after", {61'd0, busy, err, sel_start}, 64'd0);

        // Case 2b: p<2 rejected as well
        begin_req(4'd1, 4'd7);
        tick();
        chk_eq("c2b_err", {63'd0, err}, 64'd1);
        tick();

        // Case 3: e=4 shares factor with 40 -> 39 INV cycles then err
        begin_req(4'd5, 4'd11);
        provide_key(8'd4, 0);
        wait_end("c3_end", 100);
        chk_eq("c3_err", {62'd0, done, err}, 64'd1);
        chk_eq("c3_latency", t, 64'd43);
        chk_eq("c3_e", {56'd0, e}, 64'd4);
        chk_eq("c3_d", {56'd0, d}, 64'd0);
        tick();

        // Case 3b: key equal to lambda rejected on sampling
        begin_req(4'd5, 4'd11);
        provide_key(8'd40, 0);
        chk_eq("c3b_err", {62'd0, done, err}, 64'd1);
        chk_eq("c3b_e", {56'd0, e}, 64'd40);
        tick();

        // Case 3c: zero key rejected
        begin_req(4'd5, 4'd11);
        provide_key(8'd0, 2);
        chk_eq("c3c_err", {62'd0, done, err}, 64'd1);
        tick();

        // Case 4: p=7 q=13, e=5 -> d=29; start during INV ignored
        begin_req(4'd7, 4'd13);
        provide_key(8'd5, 0);
        p     = 4'd2;
        q     = 4'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_end("c4_end", 100);
        chk_eq("c4_done", {62'd0, done, err}, 64'd2);
        chk_eq("c4_latency", t, 64'd33);
        chk_eq("c4_n", {56'd0, n}, 64'd91);
        chk_eq("c4_lambda", {56'd0, lambda}, 64'd72);
        chk_eq("c4_d", {56'd0, d}, 64'd29);
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done || busy) done_cnt++;
        end
        chk_eq("c4_no_extra", done_cnt, 64'd0);

        // Case 4b: e=1 matches at the first candidate (p=2 q=5, lambda=4)
        begin_req(4'd2, 4'd5);
        provide_key(8'd1, 0);
        wait_end("c4b_end", 20);
        chk_eq("c4b_done", {62'd0, done, err}, 64'd2);
        chk_eq("c4b_latency", t, 64'd5);
        chk_eq("c4b_d", {56'd0, d}, 64'd1);
        tick();

        // Case 5: reset during INV clears outputs at once, restart gives d=27
        begin_req(4'd5, 4'd11);
        provide_key(8'd3, 0);
        repeat (5) tick();
        #2;
        reset = 1'b0;
        #1;
        chk_eq("c5_rst_outs", {busy, done, err, sel_start, n, lambda, e, d}, 64'd0);
        tick();
        reset = 1'b1;
        tick();
        chk_eq("c5_idle", {61'd0, busy, done, err}, 64'd0);
        begin_req(4'd5, 4'd11);
        provide_key(8'd3, 10);
        wait_end("c5_end", 100);
        chk_eq("c5_latency", t, 64'd41);
        chk_eq("c5_d", {56'd0, d}, 64'd27);
        tick();

        // Case 6: selector never answers
        begin_req(4'd5, 4'd11);
        err_seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (err && err_seen == 0) err_seen = t;
        end
`ifdef KEYGEN_TIMEOUT_EN
        chk_eq("c6_timeout_t", err_seen, 64'd19);
        chk_eq("c6_busy", {63'd0, busy}, 64'd0);
`else
        chk_eq("c6_no_err", err_seen, 64'd0);
        chk_eq("c6_busy", {63'd0, busy}, 64'd1);
`endif
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk_eq("c6_recover", {63'd0, busy}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
